jesd204b_tx_link_ctrl: RTL and testbench

- Link-level sequencer for the JESD204B TX data link lane.
- Generates the LMFC from SYSREF and tracks the receiver's SYNC~.
- Drives the data link's sync_request through the sequence CGS -> ILAS -> user data.
- Handles resynchronisation and error-report pulses on SYNC~, and exposes link status and counters to the transport/control logic.

---
 rtl/jesd204b_tx_link_ctrl.sv | 162 ++++++++++++++++
 tb/tb_jesd204b_tx_link_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/jesd204b_tx_link_ctrl.sv
// JESD204B TX data link sequencer.
// Builds the LMFC from SYSREF and follows the receiver's SYNC~ to step the
// lane through CGS -> ILAS -> user data. It also handles resync requests and
// error-report pulses, and exposes status flags and counters.
//
// Ports:
//   clk              lane word clock
//   reset_n          asynchronous active-low reset
//   enable           link enable; when low the FSM is held in IDLE
//   sysref           SYSREF, synchronous to clk
//   sync_n           receiver SYNC~, active-low, synchronous to clk
//   lmfc             one-cycle LMFC boundary pulse (registered)
//   sync_request     high while in CGS
//   ilas_active      high while in ILAS
//   data_active      high while in DATA
//   state            current FSM state encoding
//   sysref_seen      sticky; set by the first SYSREF rising edge
//   sysref_phase_err sticky; set by a SYSREF edge that is off the LMFC phase
//   resync_count     saturating count of resyncs triggered from DATA
//   err_count        saturating count of short SYNC~ pulses seen in DATA
module jesd204b_tx_link_ctrl #(
  parameter int OCTETS_PER_FR  = 5,
  parameter int FRAMES_PER_MF  = 4,
  parameter int OCTET_PER_SENT = 4,
  parameter int ILAS_MF        = 4,
  parameter int RESYNC_CLKS    = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       sysref,
  input  logic       sync_n,
  output logic       lmfc,
  output logic       sync_request,
  output logic       ilas_active,
  output logic       data_active,
  output logic [2:0] state,
  output logic       sysref_seen,
  output logic       sysref_phase_err,
  output logic [7:0] resync_count,
  output logic [7:0] err_count
);

  localparam int LMFC_CLKS = OCTETS_PER_FR * FRAMES_PER_MF / OCTET_PER_SENT;
  localparam int CW = (LMFC_CLKS > 1) ? $clog2(LMFC_CLKS) : 1;
  localparam int MW = (ILAS_MF > 1) ? $clog2(ILAS_MF) : 1;
  localparam int LW = $clog2(RESYNC_CLKS + 1);
  localparam logic [CW-1:0] LMFC_LAST = CW'(LMFC_CLKS - 1);
  localparam logic [MW-1:0] MF_LAST   = MW'(ILAS_MF - 1);
  localparam logic [LW-1:0] LOW_LAST  = LW'(RESYNC_CLKS - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CGS       = 3'd1,
    ILAS_WAIT = 3'd2,
    ILAS      = 3'd3,
    DATA      = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic          sysref_d;
  logic          sysref_edge;
  logic [CW-1:0] lmfc_cnt, lmfc_cnt_d;
  logic [MW-1:0] mf_cnt, mf_cnt_d;
  logic [LW-1:0] low_cnt, low_cnt_d;
  logic [7:0]    resync_count_d, err_count_d;

  assign sysref_edge = sysref & ~sysref_d;

  // An edge always realigns to 0; when it arrives with the counter on its
  // last value the realignment matches the free-running wrap, so nothing moves.
  always_comb begin
    lmfc_cnt_d = (lmfc_cnt == LMFC_LAST) ? '0 : lmfc_cnt + 1'b1;
    if (sysref_edge) lmfc_cnt_d = '0;
  end

  // lmfc is registered from the next count so it lines up with lmfc_cnt == 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sysref_d         <= 1'b0;
      lmfc_cnt         <= '0;
      lmfc             <= 1'b0;
      sysref_seen      <= 1'b0;
      sysref_phase_err <= 1'b0;
    end else begin
      sysref_d <= sysref;
      lmfc_cnt <= lmfc_cnt_d;
      lmfc     <= (lmfc_cnt_d == '0);
      if (sysref_edge) begin
        sysref_seen <= 1'b1;
        if (sysref_seen && (lmfc_cnt != LMFC_LAST)) sysref_phase_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      mf_cnt       <= '0;
      low_cnt      <= '0;
      resync_count <= '0;
      err_count    <= '0;
    end else begin
      state_q      <= state_d;
      mf_cnt       <= mf_cnt_d;
      low_cnt      <= low_cnt_d;
      resync_count <= resync_count_d;
      err_count    <= err_count_d;
    end
  end

  // low_cnt defaults to 0, so it clears on sync_n high and outside DATA.
  always_comb begin
    state_d        = state_q;
    mf_cnt_d       = mf_cnt;
    low_cnt_d      = '0;
    resync_count_d = resync_count;
    err_count_d    = err_count;
    if (!enable) begin
      state_d  = IDLE;
      mf_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE:      if (sysref_seen) state_d = CGS;
        CGS:       if (sync_n) state_d = ILAS_WAIT;
        ILAS_WAIT: begin
          if (!sync_n) state_d = CGS;
          else if (lmfc) begin
            state_d  = ILAS;
            mf_cnt_d = '0;
          end
        end
        ILAS: begin
          if (!sync_n) state_d = CGS;
          else if (lmfc) begin
            if (mf_cnt == MF_LAST) state_d = DATA;
            else mf_cnt_d = mf_cnt + 1'b1;
          end
        end
        DATA: begin
          if (!sync_n) begin
            if (low_cnt == LOW_LAST) begin
              state_d = CGS;
              if (resync_count != 8'hFF) resync_count_d = resync_count + 8'd1;
            end else begin
              low_cnt_d = low_cnt + 1'b1;
            end
          end else if (low_cnt != '0) begin
            if (err_count != 8'hFF) err_count_d = err_count + 8'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign state        = state_q;
  assign sync_request = (state_q == CGS);
  assign ilas_active  = (state_q == ILAS);
  assign data_active  = (state_q == DATA);

endmodule

// File: tb/tb_jesd204b_tx_link_ctrl.sv
module tb_jesd204b_tx_link_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       sysref;
  logic       sync_n;
  logic       lmfc;
  logic       sync_request;
  logic       ilas_active;
  logic       data_active;
  logic [2:0] state;
  logic       sysref_seen;
  logic       sysref_phase_err;
  logic [7:0] resync_count;
  logic [7:0] err_count;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  jesd204b_tx_link_ctrl #(
    .OCTETS_PER_FR (5),
    .FRAMES_PER_MF (4),
    .OCTET_PER_SENT(4),
    .ILAS_MF       (4),
    .RESYNC_CLKS   (8)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .enable          (enable),
    .sysref          (sysref),
    .sync_n          (sync_n),
    .lmfc            (lmfc),
    .sync_request    (sync_request),
    .ilas_active     (ilas_active),
    .data_active     (data_active),
    .state           (state),
    .sysref_seen     (sysref_seen),
    .sysref_phase_err(sysref_phase_err),
    .resync_count    (resync_count),
    .err_count       (err_count)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Steps until the state reaches target; an expired budget is a failed check.
  task automatic wait_state(input string tag, input logic [2:0] target, input int budget);
    int k;
    k = 0;
    while (state !== target && k < budget) begin
      tick(1);
      k++;
    end
    chk(tag, {29'd0, state}, {29'd0, target});
  endtask

  initial begin
    int n;
    reset_n = 1'b0;
    enable  = 1'b0;
    sysref  = 1'b0;
    sync_n  = 1'b0;

    // Reset with random inputs: every output held low.
    for (int i = 0; i < 4; i++) begin
      enable = 1'($urandom_range(0, 1));
      sysref = 1'($urandom_range(0, 1));
      sync_n = 1'($urandom_range(0, 1));
      tick(1);
      chk("rst_outs", {lmfc, sync_request, ilas_active, data_active, state,
                       sysref_seen, sysref_phase_err}, 32'd0);
      chk("rst_cnts", {resync_count, err_count}, 32'd0);
    end
    enable  = 1'b0;
    sysref  = 1'b0;
    sync_n  = 1'b0;
    reset_n = 1'b1;
    tick(1);

    // Enable without a SYSREF seen: stays IDLE.
    enable = 1'b1;
    tick(2);
    chk("idle_no_sysref", {29'd0, state}, 32'd0);
    chk("idle_sync_req", {31'd0, sync_request}, 32'd0);
    enable = 1'b0;

    // First SYSREF edge aligns the LMFC.
    sysref = 1'b1;
    tick(1);
    sysref = 1'b0;
    chk("sysref_seen", {31'd0, sysref_seen}, 32'd1);
    chk("first_edge_no_err", {31'd0, sysref_phase_err}, 32'd0);
    chk("lmfc_p0", {31'd0, lmfc}, 32'd1);
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      chk("lmfc_period", {31'd0, lmfc}, (i % 5 == 0) ? 32'd1 : 32'd0);
    end

    // Bring-up, phase p = 0 here.
    enable = 1'b1;
    tick(1);
    chk("cgs_state", {29'd0, state}, 32'd1);
    chk("cgs_sync_req", {31'd0, sync_request}, 32'd1);
    tick(2);
    chk("cgs_hold", {29'd0, state}, 32'd1);
    sync_n = 1'b1;
    tick(1);                                    // p = 4
    chk("ilas_wait", {29'd0, state}, 32'd2);
    chk("ilas_wait_req", {31'd0, sync_request}, 32'd0);
    tick(1);                                    // p = 5, lmfc high
    chk("ilas_wait_hold", {29'd0, state}, 32'd2);
    chk("ilas_wait_lmfc", {31'd0, lmfc}, 32'd1);
    tick(1);                                    // p = 6
    chk("ilas_enter", {29'd0, state}, 32'd3);
    chk("ilas_active_1", {31'd0, ilas_active}, 32'd1);
    for (int i = 2; i <= 20; i++) begin
      tick(1);
      chk("ilas_span", {31'd0, ilas_active}, 32'd1);
    end
    tick(1);                                    // p = 26
    chk("data_state", {29'd0, state}, 32'd4);
    chk("data_active", {31'd0, data_active}, 32'd1);
    chk("data_ilas_off", {31'd0, ilas_active}, 32'd0);

    // Short SYNC~ pulse in DATA: error report only.
    sync_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("short_hold", {29'd0, state}, 32'd4);
    end
    sync_n = 1'b1;
    tick(1);
    chk("short_err", {24'd0, err_count}, 32'd1);
    chk("short_resync", {24'd0, resync_count}, 32'd0);
    chk("short_state", {29'd0, state}, 32'd4);

    // Long SYNC~ low: resync on the 8th consecutive low cycle.
    sync_n = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick(1);
      chk("long_hold", {29'd0, state}, 32'd4);
    end
    tick(1);
    chk("long_cgs", {29'd0, state}, 32'd1);
    chk("long_sync_req", {31'd0, sync_request}, 32'd1);
    chk("long_resync", {24'd0, resync_count}, 32'd1);
    chk("long_err", {24'd0, err_count}, 32'd1);

    // Release: ILAS repeats with the same length.
    sync_n = 1'b1;
    wait_state("re_ilas_enter", 3'd3, 12);
    n = 1;
    tick(1);
    while (ilas_active === 1'b1 && n < 40) begin
      n++;
      tick(1);
    end
    chk("re_ilas_len", n, 32'd20);
    chk("re_data", {29'd0, state}, 32'd4);

    // Find an LMFC boundary, then in-phase SYSREF.
    n = 0;
    while (lmfc !== 1'b1 && n < 10) begin
      tick(1);
      n++;
    end
    chk("lmfc_found", {31'd0, lmfc}, 32'd1);
    tick(4);                                    // counter on its last value
    sysref = 1'b1;
    tick(1);
    sysref = 1'b0;
    chk("inphase_lmfc", {31'd0, lmfc}, 32'd1);
    chk("inphase_no_err", {31'd0, sysref_phase_err}, 32'd0);
    tick(5);
    chk("inphase_period", {31'd0, lmfc}, 32'd1);

    // Off-phase SYSREF two cycles after a boundary.
    tick(2);
    sysref = 1'b1;
    tick(1);
    sysref = 1'b0;
    chk("offphase_err", {31'd0, sysref_phase_err}, 32'd1);
    chk("offphase_lmfc", {31'd0, lmfc}, 32'd1);
    for (int i = 1; i <= 5; i++) begin
      tick(1);
      chk("rephase_lmfc", {31'd0, lmfc}, (i == 5) ? 32'd1 : 32'd0);
    end
    chk("offphase_data", {29'd0, state}, 32'd4);

    // Abort mid-ILAS.
    sync_n = 1'b0;
    tick(8);
    chk("abort_resync", {24'd0, resync_count}, 32'd2);
    sync_n = 1'b1;
    wait_state("abort_ilas", 3'd3, 12);
    tick(5);
    chk("abort_mid_ilas", {29'd0, state}, 32'd3);
    enable = 1'b0;
    tick(1);
    chk("abort_idle", {29'd0, state}, 32'd0);
    chk("abort_ilas_off", {31'd0, ilas_active}, 32'd0);
    chk("abort_keep_flags", {30'd0, sysref_seen, sysref_phase_err}, 32'd3);
    enable = 1'b1;
    tick(1);
    chk("reenable_cgs", {29'd0, state}, 32'd1);
    chk("reenable_cnts", {16'd0, resync_count, err_count}, {16'd0, 8'd2, 8'd1});

    // Asynchronous reset takes effect without a clock edge.
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst", {resync_count, err_count, 5'd0, state,
                      sysref_seen, sysref_phase_err, lmfc, sync_request}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
